// File: rtl/key_led_pkg.sv
// Shared types and helpers for the key/LED control block.
// Optional long-press support is selected with the KEY_LONG_PRESS_EN macro.
package key_led_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK      = 2'd0,
        MODE_CHASE_UP   = 2'd1,
        MODE_CHASE_DOWN = 2'd2,
        MODE_OFF        = 2'd3
    } mode_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width = width + 1;
        return width;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key synchroniser, debouncer and press pulse generator.
// With KEY_LONG_PRESS_EN defined, also emits a one-shot long-press pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_W      = 14,
    parameter int unsigned KEY_ACTIVE_HIGH = 1
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_W          = 26
`endif
) (
    input  logic clk_50m,
    input  logic reset,
    input  logic key_in,
    output logic key_level,
    output logic key_press
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic key_long
`endif
);

    localparam int unsigned DEB_LIMIT = 2 ** (DEBOUNCE_W - 1);
    // Synchroniser resets to the idle pin level so the mapped value starts unpressed.
    localparam logic IDLE_PIN = (KEY_ACTIVE_HIGH == 0);

    logic [1:0]            sync;
    logic                  synced;
    logic [DEBOUNCE_W-1:0] deb_cnt;

    assign synced = (KEY_ACTIVE_HIGH != 0) ? sync[1] : ~sync[1];

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            sync      <= {2{IDLE_PIN}};
            deb_cnt   <= '0;
            key_level <= 1'b0;
            key_press <= 1'b0;
        end else begin
            sync      <= {sync[0], key_in};
            key_press <= 1'b0;
            if (synced == key_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEBOUNCE_W'(DEB_LIMIT - 1)) begin
                key_level <= synced;
                key_press <= synced;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned HOLD_W     = LONG_W + 1;
    localparam int unsigned LONG_LIMIT = 2 ** LONG_W;

    logic [HOLD_W-1:0] hold_cnt;

    // Counter saturates at the threshold, so the pulse fires once per press.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (!key_level) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_W'(LONG_LIMIT)) begin
                hold_cnt <= hold_cnt + 1'b1;
                key_long <= (hold_cnt == HOLD_W'(LONG_LIMIT - 1));
            end
        end
    end
`endif

endmodule

// File: rtl/key_led_ctrl.sv
// Key debouncing, LED mode FSM and pattern rendering with a heartbeat output.
// Define KEY_LONG_PRESS_EN to add the key_long port and long-press return to BLINK.
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned NUM_LEDS        = 4,
    parameter int unsigned DEBOUNCE_W      = 14,
    parameter int unsigned BLINK_W         = 28,
    parameter int unsigned KEY_ACTIVE_HIGH = 1,
    parameter int unsigned LONG_W          = 26
) (
    input  logic                clk_50m,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [1:0]          mode_o,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                heartbeat_o
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic [NUM_KEYS-1:0] key_long
`endif
);

    localparam int unsigned      IDX_W    = clog2(NUM_LEDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);

    logic [BLINK_W-1:0]  cnt;
    logic                step;
    logic                press_off;
    mode_t               mode;
    logic [IDX_W-1:0]    idx;
    logic [NUM_LEDS-1:0] onehot;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_W      (DEBOUNCE_W),
            .KEY_ACTIVE_HIGH (KEY_ACTIVE_HIGH)
`ifdef KEY_LONG_PRESS_EN
            ,
            .LONG_W          (LONG_W)
`endif
        ) u_deb (
            .clk_50m   (clk_50m),
            .reset     (reset),
            .key_in    (key_in[k]),
            .key_level (key_level[k]),
            .key_press (key_press[k])
`ifdef KEY_LONG_PRESS_EN
            ,
            .key_long  (key_long[k])
`endif
        );
    end

    if (NUM_KEYS > 2) begin : g_off_key
        assign press_off = key_press[2];
    end else begin : g_no_off_key
        assign press_off = 1'b0;
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign step        = &cnt[BLINK_W-3:0];
    assign heartbeat_o = cnt[BLINK_W-2];
    assign mode_o      = mode;

    // Any mode event takes priority over a coincident chase step.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            mode <= MODE_BLINK;
            idx  <= '0;
        end else if (key_press[0] && key_press[1]) begin
            mode <= MODE_BLINK;
        end else if (key_press[0]) begin
            mode <= MODE_CHASE_UP;
            idx  <= '0;
        end else if (key_press[1]) begin
            mode <= MODE_CHASE_DOWN;
            idx  <= IDX_LAST;
        end else if (press_off) begin
            mode <= MODE_OFF;
`ifdef KEY_LONG_PRESS_EN
        end else if (|key_long) begin
            mode <= MODE_BLINK;
`endif
        end else if (step) begin
            if (mode == MODE_CHASE_UP) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else if (mode == MODE_CHASE_DOWN) begin
                idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
            end
        end
    end

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            led_o <= '0;
        end else begin
            case (mode)
                MODE_BLINK:                     led_o <= {NUM_LEDS{cnt[BLINK_W-2]}};
                MODE_CHASE_UP, MODE_CHASE_DOWN: led_o <= onehot;
                default:                        led_o <= '0;
            endcase
        end
    end

endmodule
